cam_frame_sched: RTL

Camera-side frame write scheduler in the cmos_pclk domain. It counts 16-bit camera words from the recv_cam output and cuts them into fixed-size SDRAM write bursts. Burst requests go to the 133 MHz write engine over a toggle req/ack handshake. It also owns double-buffer (ping-pong) bank selection, so the display side only ever reads a completely written frame, and it detects short, long and corrupted frames.

---
 rtl/cam_sched_pkg.sv | 24 ++
 rtl/toggle_sync2.sv | 33 +++
 rtl/cam_frame_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_sched_pkg.sv
// Shared types and defaults for the camera-side frame write scheduler.
// Holds the FSM state encoding, sizing defaults and error-bit positions.
package cam_sched_pkg;

  localparam int DEF_BURST_WORDS = 512;
  localparam int DEF_FRAME_ROWS  = 600;
  localparam int DEF_MAX_PEND    = 4;
  localparam int DEF_ROW_W       = 13;

  localparam int ERR_OVF   = 0;
  localparam int ERR_PROTO = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DRAIN   = 2'd3
  } sched_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/toggle_sync2.sv
// Two-flop synchroniser for an asynchronous level/toggle input.
// toggle_o flags any change of the synchronised level; rise = toggle_o & level_o.
module toggle_sync2 (
  input  logic cmos_pclk,
  input  logic rst_133,
  input  logic async_i,
  output logic level_o,
  output logic toggle_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], async_i};
    prev_d = sync_q[1];
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o  = sync_q[1];
  assign toggle_o = sync_q[1] ^ prev_q;

endmodule

// File: rtl/cam_frame_sched.sv
// Cuts the camera word stream into SDRAM bursts, hands them to the write engine
// over a toggle handshake and ping-pongs banks so display only sees whole frames.
module cam_frame_sched
  import cam_sched_pkg::*;
#(
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int FRAME_ROWS  = DEF_FRAME_ROWS,
  parameter int MAX_PEND    = DEF_MAX_PEND,
  parameter int ROW_W       = DEF_ROW_W
) (
  input  logic             cmos_pclk,
  input  logic             rst_133,
  input  logic             cfg_done,
  input  logic             cmos_vsyn,
  input  logic             data_16b_en,
  input  logic             burst_ack_tgl,
  output logic             burst_req_tgl,
  output logic [ROW_W-1:0] burst_row,
  output logic             burst_bank,
  output logic             burst_discard,
  output logic             disp_bank,
  output logic             frame_done,
  output logic             fifo_flush,
  output logic [7:0]       drop_cnt,
  output logic [1:0]       err_sticky
);

  localparam int WCNT_W = $clog2(BURST_WORDS);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  logic vs_level, vs_toggle, vs_rise;
  logic ack_sync, ack_edge, outstanding;

  toggle_sync2 u_vs_sync (
    .cmos_pclk (cmos_pclk),
    .rst_133   (rst_133),
    .async_i   (cmos_vsyn),
    .level_o   (vs_level),
    .toggle_o  (vs_toggle)
  );

  toggle_sync2 u_ack_sync (
    .cmos_pclk (cmos_pclk),
    .rst_133   (rst_133),
    .async_i   (burst_ack_tgl),
    .level_o   (ack_sync),
    .toggle_o  (ack_edge)
  );

  assign vs_rise = vs_toggle & vs_level;

  sched_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              bad_q, bad_d;
  logic              req_q, req_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              bank_q, bank_d;
  logic              disc_q, disc_d;
  logic              wr_bank_q, wr_bank_d;
  logic              disp_bank_q, disp_bank_d;
  logic              frame_done_q, frame_done_d;
  logic              fifo_flush_q, fifo_flush_d;
  logic [7:0]        drop_q, drop_d;
  logic [1:0]        err_q, err_d;

  logic word_wrap, ack_consume;

  assign outstanding = (req_q != ack_sync);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pend_d       = pend_q;
    rows_d       = rows_q;
    bad_d        = bad_q;
    req_d        = req_q;
    row_d        = row_q;
    bank_d       = bank_q;
    disc_d       = disc_q;
    wr_bank_d    = wr_bank_q;
    disp_bank_d  = disp_bank_q;
    frame_done_d = 1'b0;
    fifo_flush_d = 1'b0;
    drop_d       = drop_q;
    err_d        = err_q;
    word_wrap    = 1'b0;

    // A stray ack after a flush must not underflow pend.
    ack_consume = ack_edge && (pend_q != '0);
    if (ack_edge && (rows_q != '1))
      rows_d = rows_q + 1'b1;

    if ((state_q == ACTIVE) && data_16b_en) begin
      wcnt_d    = wcnt_q + 1'b1;
      word_wrap = (wcnt_q == WCNT_W'(BURST_WORDS - 1));
    end

    if (word_wrap && !ack_consume) begin
      if (pend_q == PEND_W'(MAX_PEND)) begin
        err_d[ERR_OVF] = 1'b1;
        bad_d          = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!word_wrap && ack_consume) begin
      pend_d = pend_q - 1'b1;
    end

    // Hold off issue in the ack cycle: rows/pend only reflect the ack one cycle later.
    if ((pend_q != '0) && !outstanding && !ack_edge) begin
      req_d  = ~req_q;
      bank_d = wr_bank_q;
      if (rows_q < ROW_W'(FRAME_ROWS)) begin
        row_d  = rows_q;
        disc_d = 1'b0;
      end else begin
        row_d  = ROW_W'(FRAME_ROWS - 1);
        disc_d = 1'b1;
        bad_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_done) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          wcnt_d  = '0;
          rows_d  = '0;
          bad_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d = DRAIN;
          if (wcnt_d != '0) begin
            bad_d        = 1'b1;
            fifo_flush_d = 1'b1;
            wcnt_d       = '0;
          end
        end
      end
      DRAIN: begin
        if (data_16b_en) begin
          err_d[ERR_PROTO] = 1'b1;
          fifo_flush_d     = 1'b1;
          drop_d           = sat_inc8(drop_q);
          pend_d           = '0;
          state_d          = WAIT_VS;
        end else if ((pend_q == '0) && !outstanding && (wcnt_q == '0)) begin
          if ((rows_q == ROW_W'(FRAME_ROWS)) && !bad_q) begin
            disp_bank_d  = wr_bank_q;
            wr_bank_d    = ~wr_bank_q;
            frame_done_d = 1'b1;
          end else begin
            drop_d = sat_inc8(drop_q);
          end
          state_d = ACTIVE;
          wcnt_d  = '0;
          rows_d  = '0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_done) begin
      state_d      = IDLE;
      wcnt_d       = '0;
      pend_d       = '0;
      rows_d       = '0;
      bad_d        = 1'b0;
      fifo_flush_d = (state_q != IDLE);
    end
  end

  // NOTE: only control/status flops exist here, so all of them take the async reset.
  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      pend_q       <= '0;
      rows_q       <= '0;
      bad_q        <= 1'b0;
      req_q        <= 1'b0;
      row_q        <= '0;
      bank_q       <= 1'b0;
      disc_q       <= 1'b0;
      wr_bank_q    <= 1'b0;
      disp_bank_q  <= 1'b0;
      frame_done_q <= 1'b0;
      fifo_flush_q <= 1'b0;
      drop_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      pend_q       <= pend_d;
      rows_q       <= rows_d;
      bad_q        <= bad_d;
      req_q        <= req_d;
      row_q        <= row_d;
      bank_q       <= bank_d;
      disc_q       <= disc_d;
      wr_bank_q    <= wr_bank_d;
      disp_bank_q  <= disp_bank_d;
      frame_done_q <= frame_done_d;
      fifo_flush_q <= fifo_flush_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  assign burst_req_tgl = req_q;
  assign burst_row     = row_q;
  assign burst_bank    = bank_q;
  assign burst_discard = disc_q;
  assign disp_bank     = disp_bank_q;
  assign frame_done    = frame_done_q;
  assign fifo_flush    = fifo_flush_q;
  assign drop_cnt      = drop_q;
  assign err_sticky    = err_q;

endmodule
